// File: rtl/quick_uart_pkg.sv
// Shared types for the quick_uart transmit path.
// The arbiter state encoding is fixed so other blocks can decode busy from it.
package quick_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } quick_uart_arb_state_t;

endpackage

// File: rtl/quick_uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward
// from last_grant+1, wrapping to 0. Reusable for any shared resource.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    // Offset 1..NUM_REQ so the previous owner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/quick_uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one quick_uart_tx between
// NUM_REQ byte streams, with a one-entry holding register and stall watchdog.
module quick_uart_tx_arbiter
  import quick_uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         tx_valid_o,
  output logic [DATA_BITS-1:0]         tx_data_o,
  input  logic                         tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  quick_uart_arb_state_t state;
  logic [IW-1:0]         grant;
  logic [IW-1:0]         last_grant;
  logic                  hold_valid;
  logic [DATA_BITS-1:0]  hold_data;
  logic [CW-1:0]         stall_cnt;
  logic                  timeout;

  logic [IW-1:0]         pick;
  logic                  pick_any;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_BITS-1:0]  sel_data;
  logic                  slot_free;
  logic                  accept;
  logic                  stall;
  logic [CW-1:0]         stall_next;
  logic                  fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .idx        (pick),
    .any        (pick_any)
  );

  assign sel_valid = req_valid_i[grant];
  assign sel_last  = req_last_i[grant];
  assign sel_data  = req_data_i[grant*DATA_BITS +: DATA_BITS];

  // The slot frees in the same cycle the transmitter takes the held byte.
  assign slot_free = !hold_valid || tx_ready_i;
  assign accept    = (state == SEND) && sel_valid && slot_free;
  assign stall     = (state == SEND) && !sel_valid;

  assign stall_next = (stall_cnt == {CW{1'b1}}) ? stall_cnt : stall_cnt + 1'b1;
  assign fire       = (TIMEOUT != 0) && stall && (stall_next >= TO_VAL);

  always_comb begin
    req_ready_o = '0;
    if (state == SEND) req_ready_o[grant] = slot_free;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      hold_valid <= 1'b0;
      hold_data  <= '0;
      stall_cnt  <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;

      // Holding register drains regardless of arbitration state.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= sel_data;
      end else if (hold_valid && tx_ready_i) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick;
            last_grant <= pick;
            stall_cnt  <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          // A completing accept takes priority over the watchdog.
          if (accept) begin
            stall_cnt <= '0;
            if (sel_last) state <= IDLE;
          end else if (fire) begin
            stall_cnt <= '0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else if (stall) begin
            stall_cnt <= stall_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_valid_o = hold_valid;
  assign tx_data_o  = hold_data;
  assign grant_o    = grant;
  assign busy_o     = (state == SEND);
  assign timeout_o  = timeout;

endmodule

// File: tb/tb_quick_uart_tx_arbiter.sv
// Directed bench: per-requester byte queues feed the DUT, a scoreboard queue
// holds the expected transmit order and a negedge monitor checks every transfer.
module tb_quick_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DB-1:0] req_data;
  logic            tx_valid, tx_ready;
  logic [DB-1:0]   tx_data;
  logic [1:0]      grant;
  logic            busy, timeout;

  always #5 clk = ~clk;

  quick_uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  beat_t      rq[N][$];
  logic [7:0] sb[$];
  int         grant_log[$];
  int         total = 0;
  int         passed = 0;
  bit         pat_en = 1'b0;
  int         pat_cyc = 0;
  bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit         prev_busy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DB +: DB] = rq[i][0].d;
        req_last[i]          = rq[i][0].last;
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DB +: DB] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic add(input int i, input logic [7:0] d, input logic last, input bit expect_tx);
    beat_t b;
    b.d = d;
    b.last = last;
    rq[i].push_back(b);
    if (expect_tx) sb.push_back(d);
  endtask

  // One clock: handshake seen at negedge, queues advance after the edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && !rst && rq[i].size() > 0) void'(rq[i].pop_front());
    if (pat_en) begin
      tx_ready = pat[pat_cyc % 4];
      pat_cyc++;
    end
    if (busy && !prev_busy) grant_log.push_back(int'(grant));
    prev_busy = busy;
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rq[i].delete();
    sb.delete();
    rst = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    grant_log.delete();
    prev_busy = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() > 0 || busy || tx_valid) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 300), 32'd1);
  endtask

  // Transfer monitor: scoreboard order, hold stability, ready under backpressure.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (tx_valid === 1'b1 && tx_data === prev_data) passed++;
          else $display("FAIL hold_stable: got v=%0b d=%0h expected v=1 d=%0h", tx_valid, tx_data, prev_data);
        end
        if (tx_valid && !tx_ready) begin
          total++;
          if (req_ready === '0) passed++;
          else $display("FAIL ready_when_full: got %0b expected 0", req_ready);
        end
        if (tx_valid && tx_ready) begin
          total++;
          if (sb.size() == 0) begin
            $display("FAIL tx_unexpected: got %0h expected no transfer", tx_data);
          end else begin
            e = sb.pop_front();
            if (tx_data === e) passed++;
            else $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    tx_ready = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;

    // Reset state
    do_reset();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Single requester
    add(2, 8'h41, 1'b0, 1'b1);
    add(2, 8'h42, 1'b1, 1'b1);
    drive();
    tick();
    check("single_grant", 32'(grant), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_first", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h41});
    tick();
    check("single_second", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h42});
    check("single_busy_fall", 32'(busy), 32'd0);
    drain("single");

    // Round-robin
    do_reset();
    add(0, 8'h00, 1'b1, 1'b1);
    add(1, 8'h10, 1'b1, 1'b1);
    add(3, 8'h30, 1'b1, 1'b1);
    add(0, 8'h01, 1'b1, 1'b1);
    drive();
    drain("rr");
    check("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("rr_g0", 32'(grant_log[0]), 32'd0);
      check("rr_g1", 32'(grant_log[1]), 32'd1);
      check("rr_g2", 32'(grant_log[2]), 32'd3);
      check("rr_g3", 32'(grant_log[3]), 32'd0);
    end

    // Atomicity
    do_reset();
    add(0, 8'h90, 1'b0, 1'b1);
    add(0, 8'h91, 1'b0, 1'b1);
    add(0, 8'h92, 1'b1, 1'b1);
    add(1, 8'hA0, 1'b1, 1'b1);
    drive();
    drain("atomic");

    // Backpressure
    do_reset();
    pat_en = 1'b1;
    pat_cyc = 0;
    add(0, 8'hB0, 1'b0, 1'b1);
    add(0, 8'hB1, 1'b0, 1'b1);
    add(0, 8'hB2, 1'b0, 1'b1);
    add(0, 8'hB3, 1'b1, 1'b1);
    drive();
    drain("bp");
    pat_en = 1'b0;
    tx_ready = 1'b1;

    // Watchdog
    do_reset();
    add(1, 8'h51, 1'b0, 1'b1);
    add(2, 8'h61, 1'b1, 1'b1);
    drive();
    k = 0;
    while (rq[1].size() > 0 && k < 20) begin
      tick();
      k++;
    end
    check("wd_first_grant", 32'(grant), 32'd1);
    k = 0;
    while (timeout !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("wd_stall_cycles", 32'(k), 32'd8);
    check("wd_idle", 32'(busy), 32'd0);
    tick();
    check("wd_pulse_once", 32'(timeout), 32'd0);
    check("wd_next_grant", 32'(grant), 32'd2);
    check("wd_next_busy", 32'(busy), 32'd1);
    drain("wd");

    // Reset mid-packet
    do_reset();
    tx_ready = 1'b0;
    add(0, 8'h70, 1'b0, 1'b0);
    add(0, 8'h71, 1'b1, 1'b0);
    drive();
    k = 0;
    while (tx_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("mid_hold_full", 32'(tx_valid), 32'd1);
    for (int i = 0; i < N; i++) rq[i].delete();
    rst = 1'b1;
    drive();
    tick();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    prev_busy = 1'b0;
    add(2, 8'h82, 1'b1, 1'b1);
    add(3, 8'h83, 1'b1, 1'b1);
    drive();
    tick();
    check("mid_post_grant", 32'(grant), 32'd2);
    drain("mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quick_uart_tx_arbiter.md
# quick_uart_tx_arbiter

Shares a single `quick_uart_tx` transmitter between `NUM_REQ` byte-stream requesters. Requesters are served round-robin. Packets are atomic: once a requester is granted, it keeps the UART until it hands over a byte marked `last`, or until a stall watchdog expires. The block sits directly upstream of `quick_uart_tx`: its `tx_*` ports connect to that block's `valid_i`, `ready_o` and `data_i`.

## Interface
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `DATA_BITS`, default 8: byte width; must match the transmitter.
- `TIMEOUT`, default 1024: number of stalled cycles after which the grant is revoked; 0 disables the watchdog.
- `clk_i`  in  1: the single clock.
- `rst_i`  in  1: reset, synchronous and active-high.
- `req_valid_i`  in  NUM_REQ: per-requester byte valid.
- `req_data_i`  in  NUM_REQ*DATA_BITS: per-requester byte; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- `req_last_i`  in  NUM_REQ: the current byte ends the packet.
- `req_ready_o`  out  NUM_REQ: per-requester accept; at most one bit is high.
- `tx_valid_o`  out  1: byte available to the transmitter.
- `tx_data_o`  out  DATA_BITS: byte to the transmitter.
- `tx_ready_i`  in  1: transmitter ready.
- `grant_o`  out  $clog2(NUM_REQ): index of the current or most recent owner.
- `busy_o`  out  1: high while in SEND.
- `timeout_o`  out  1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- State machine states: IDLE and SEND.
- IDLE:
  - If any `req_valid_i` is high, select the first valid requester searching upward from `last_grant+1` (wrapping to 0).
  - Register the selection into `grant_o` and `last_grant`.
  - Go to SEND on the next cycle.
  - If no requester is valid, stay in IDLE.
- SEND, accept path:
  - `req_ready_o[grant]` = `!hold_valid || tx_ready_i`; all other ready bits are 0.
  - An accept is `req_valid_i[grant] && req_ready_o[grant]`.
  - An accept loads the byte into a one-entry holding register.
  - The holding register drives `tx_valid_o` and `tx_data_o`.
  - The holding register clears when `tx_ready_i && tx_valid_o` and no new accept happens in the same cycle.
- SEND, end of packet:
  - An accept with `req_last_i[grant]` high returns the block to IDLE.
  - The holding register keeps draining independently of the state.
- Watchdog:
  - The stall counter increments on each SEND cycle where `req_valid_i[grant]` is 0.
  - It clears on every accept and on entry to SEND.
  - When the counter reaches `TIMEOUT` (with `TIMEOUT` ≠ 0), go to IDLE and pulse `timeout_o`.
  - The partially sent packet is abandoned; no byte is invented.
- Simultaneous events:
  - An accept of `last` in the same cycle the watchdog would fire counts as a normal completion; `timeout_o` stays 0.
  - In IDLE, a requester that dropped valid is skipped.
  - The previous owner wins only if no other requester is valid.
- Reset (also when asserted mid-packet):
  - State goes to IDLE; the holding register empties.
  - `tx_valid_o`=0, `tx_data_o`=0, `req_ready_o`=0, `grant_o`=0, `busy_o`=0, `timeout_o`=0.
  - `last_grant` is set to NUM_REQ-1, so requester 0 wins first.
  - Any byte in the holding register is discarded.

## Timing
- Arbitration latency: request valid in IDLE at cycle n, grant registered at n+1, first `req_ready_o` possible at n+1.
- Data latency: byte accepted at cycle n appears on `tx_valid_o`/`tx_data_o` at n+1.
- Throughput: one byte per cycle while `tx_ready_i` is held high.
- Packet turnaround: at least one IDLE cycle between packets.
- `tx_valid_o` never drops and `tx_data_o` never changes until a transfer completes.
- Only `req_ready_o` depends combinationally on an input (`tx_ready_i`); all other outputs come from registers.
- Stall counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- The shared package `quick_uart_pkg` holds the state enum `quick_uart_arb_state_t` (IDLE=1'b0, SEND=1'b1).
- Sub-module `rr_arbiter`: combinational round-robin picker.
  - Inputs: request vector, last grant.
  - Outputs: index, any-valid flag.
  - Reusable by other shared resources.
- Holding register, stall counter and state machine live in this module.

## Test plan
- Single requester: req 2 sends 0x41, 0x42(last) with `tx_ready_i`=1.
  - `grant_o`=2; tx sees 0x41 then 0x42 on consecutive cycles; `busy_o` falls after 0x42 is accepted.
- Round-robin: reqs 0, 1 and 3 all valid with 1-byte packets from reset.
  - Grant order is 0, 1, 3, 0; req 2 is never granted.
- Atomicity: req 0 sends a 3-byte packet while req 1 is valid throughout.
  - All 3 bytes of req 0 are transmitted before any byte of req 1.
- Backpressure: `tx_ready_i` toggles 1,0,0,1 during a 4-byte packet.
  - `tx_data_o` is stable while stalled; bytes arrive in order; `req_ready_o` is low while the holding register is full and `tx_ready_i`=0.
- Watchdog (TIMEOUT=8): req 1 sends 1 byte without last, then drops valid.
  - `timeout_o` pulses after 8 stall cycles; next cycle the block is IDLE; req 2, pending, is granted.
- Reset mid-packet: assert `rst_i` while the holding register is full.
  - Next cycle: `tx_valid_o`=0, `busy_o`=0, `grant_o`=0; the first post-reset grant goes to the lowest valid index.
